// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB)
// plus a pattern history table (PHT) of 2-bit saturating counters.
// Prediction is purely combinational from the fetch PC and the registered
// tables. Resolved branches from EX train both tables on the clock edge.
//
// Optional feature macro: BP_GSHARE_EN
//   defined   -> gshare: PHT index = PC index bits XOR global history,
//                pred_hist = BHR
//   undefined -> bimodal: PHT index = PC index bits, pred_hist = 0,
//                update_hist ignored (BHR still maintained)
//
// Ports
//   clk            in   clock
//   reset_n        in   asynchronous active-low reset
//   pc             in   current fetch PC (32)
//   prediction     out  1 = predicted taken
//   pre_pc         out  predicted next PC (32)
//   pred_hist      out  history value used for this prediction (HIST_BITS)
//   update_valid   in   a branch/jump resolved this cycle
//   update_pc      in   PC of the resolved instruction (32)
//   update_taken   in   actual direction
//   update_target  in   actual taken target (32)
//   update_hist    in   pred_hist that travelled with the instruction
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES   = 32,
    parameter int IDX       = $clog2(ENTRIES),
    parameter int HIST_BITS = IDX
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          pc,
    output logic                 prediction,
    output logic [31:0]          pre_pc,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 update_valid,
    input  logic [31:0]          update_pc,
    input  logic                 update_taken,
    input  logic [31:0]          update_target,
    input  logic [HIST_BITS-1:0] update_hist
);

    localparam int TAG_W = 30 - IDX;

    // Table state
    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    logic [1:0]           pht_q    [ENTRIES];
    logic [HIST_BITS-1:0] bhr_q;

    // Next-state values for the single entry touched by an update
    logic [1:0]           pht_d;
    logic [HIST_BITS-1:0] bhr_d;

    // Address fields
    logic [IDX-1:0]   pred_bidx;
    logic [IDX-1:0]   pred_pidx;
    logic [TAG_W-1:0] pred_tag;
    logic [IDX-1:0]   upd_bidx;
    logic [IDX-1:0]   upd_pidx;
    logic [TAG_W-1:0] upd_tag;
    logic             hit;

    assign pred_bidx = pc[IDX+1:2];
    assign pred_tag  = pc[31:IDX+2];
    assign upd_bidx  = update_pc[IDX+1:2];
    assign upd_tag   = update_pc[31:IDX+2];

`ifdef BP_GSHARE_EN
    assign pred_pidx = pred_bidx ^ bhr_q;
    // Train the counter that was actually consulted at predict time,
    // using the history carried with the instruction.
    assign upd_pidx  = upd_bidx ^ update_hist;
    assign pred_hist = bhr_q;
`else
    assign pred_pidx = pred_bidx;
    assign upd_pidx  = upd_bidx;
    assign pred_hist = '0;
`endif

    // Bits that do not feed any logic in one or both builds
    logic unused_bits;
    assign unused_bits = ^{update_hist, bhr_q, update_pc[1:0]};

    // ---------------- Predict (combinational) ----------------
    always_comb begin
        hit        = valid_q[pred_bidx] && (tag_q[pred_bidx] == pred_tag);
        prediction = hit && pht_q[pred_pidx][1];
        // 32-bit add wraps naturally (0xFFFFFFFC + 4 = 0)
        pre_pc     = prediction ? target_q[pred_bidx] : (pc + 32'd4);
    end

    // ---------------- Update next-state ----------------
    always_comb begin
        pht_d = pht_q[upd_pidx];
        if (update_taken) begin
            if (pht_q[upd_pidx] != 2'b11) pht_d = pht_q[upd_pidx] + 2'b01;
        end else begin
            if (pht_q[upd_pidx] != 2'b00) pht_d = pht_q[upd_pidx] - 2'b01;
        end
        bhr_d = {bhr_q[HIST_BITS-2:0], update_taken};
    end

    // ---------------- Table registers ----------------
    // No write-to-read bypass: a same-cycle prediction sees pre-edge state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            bhr_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                pht_q[i]    <= 2'b01;
            end
        end else if (update_valid) begin
            pht_q[upd_pidx] <= pht_d;
            bhr_q           <= bhr_d;
            // Not-taken outcomes leave the BTB untouched; taken ones
            // overwrite whatever entry aliases at this index.
            if (update_taken) begin
                valid_q[upd_bidx]  <= 1'b1;
                tag_q[upd_bidx]    <= upd_tag;
                target_q[upd_bidx] <= update_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int HB = 5;
  localparam int W  = 1 + 32 + HB;

  logic          clk;
  logic          reset_n;
  logic [31:0]   pc;
  logic          prediction;
  logic [31:0]   pre_pc;
  logic [HB-1:0] pred_hist;
  logic          update_valid;
  logic [31:0]   update_pc;
  logic          update_taken;
  logic [31:0]   update_target;
  logic [HB-1:0] update_hist;

  int checks   = 0;
  int failures = 0;

  // scoreboard: expected {prediction, pre_pc, pred_hist}
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  branch_predictor #(.ENTRIES(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc            (pc),
    .prediction    (prediction),
    .pre_pc        (pre_pc),
    .pred_hist     (pred_hist),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .update_hist   (update_hist)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  // Outputs are combinational and always present; sample on the falling
  // edge, away from the rising edge where updates land.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = {prediction, pre_pc, pred_hist};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s: got pred=%0b pre_pc=%08h hist=%b, expected pred=%0b pre_pc=%08h hist=%b",
                 n, g[W-1], g[W-2:HB], g[HB-1:0], e[W-1], e[W-2:HB], e[HB-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string n, input logic [31:0] p, input logic ep,
                     input logic [31:0] epc, input logic [HB-1:0] eh);
    pc = p;
    exp_q.push_back({ep, epc, eh});
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  // Present one update for exactly one rising edge.
  task automatic do_update(input logic [31:0] upc, input logic t,
                           input logic [31:0] tgt, input logic [HB-1:0] h);
    @(posedge clk);
    #1;
    update_valid  = 1'b1;
    update_pc     = upc;
    update_taken  = t;
    update_target = tgt;
    update_hist   = h;
    @(posedge clk);
    #1;
    update_valid  = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n       = 1'b0;
    pc            = 32'h100;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_target = '0;
    update_hist   = '0;

    // reset state, observed while reset is still held
    chk("reset_pc100", 32'h100, 1'b0, 32'h104, '0);
    chk("reset_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("post_reset_pc100", 32'h100, 1'b0, 32'h104, '0);

`ifndef BP_GSHARE_EN
    // first taken update: counter 01 -> 10, BTB filled
    do_update(32'h100, 1'b1, 32'h200, '0);
    chk("first_taken", 32'h100, 1'b1, 32'h200, '0);

    // update inputs without update_valid must be ignored
    @(posedge clk);
    #1;
    update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h500;
    @(posedge clk);
    #1;
    chk("ignored_update", 32'h100, 1'b1, 32'h200, '0);

    // alias: 0x180 shares index 0 with a different tag
    chk("alias_miss", 32'h180, 1'b0, 32'h184, '0);
    do_update(32'h180, 1'b1, 32'h300, '0);
    chk("alias_evicts_100", 32'h100, 1'b0, 32'h104, '0);
    chk("alias_hit_180", 32'h180, 1'b1, 32'h300, '0);

    // saturation from a clean reset
    apply_reset();
    for (int i = 0; i < 4; i++) do_update(32'h100, 1'b1, 32'h200, '0);
    chk("sat_11", 32'h100, 1'b1, 32'h200, '0);
    do_update(32'h100, 1'b0, 32'h0, '0);
    chk("sat_dec_10", 32'h100, 1'b1, 32'h200, '0);
    do_update(32'h100, 1'b0, 32'h0, '0);
    chk("sat_dec_01", 32'h100, 1'b0, 32'h104, '0);
    // saturate low: two more NT keep it at 00; one T only reaches 01
    do_update(32'h100, 1'b0, 32'h0, '0);
    do_update(32'h100, 1'b0, 32'h0, '0);
    do_update(32'h100, 1'b1, 32'h200, '0);
    chk("sat_low_then_t", 32'h100, 1'b0, 32'h104, '0);

    // same-edge read and write: pre-edge value seen in the update cycle
    apply_reset();
    @(posedge clk);
    #1;
    update_valid  = 1'b1;
    update_pc     = 32'h100;
    update_taken  = 1'b1;
    update_target = 32'h200;
    chk("same_edge_before", 32'h100, 1'b0, 32'h104, '0);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    chk("same_edge_after", 32'h100, 1'b1, 32'h200, '0);

    // async reset between edges drops the prediction immediately
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back({1'b0, 32'h104, {HB{1'b0}}});
    name_q.push_back("async_reset");
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    chk("after_async_reset", 32'h100, 1'b0, 32'h104, '0);
`else
    // gshare: T, T, NT; PCs chosen so all three train PHT[13]
    // hist 0 ^ idx13 = 13 -> 10 ; hist 1 ^ idx12 = 13 -> 11 ; hist 3 ^ idx14 = 13 -> 10
    do_update(32'h134, 1'b1, 32'h400, 5'b00000);
    chk("gs_hist_1", 32'h0, 1'b0, 32'h4, 5'b00001);
    do_update(32'h130, 1'b1, 32'h400, 5'b00001);
    do_update(32'h138, 1'b0, 32'h0,   5'b00011);
    chk("gs_hist_00110", 32'h100, 1'b0, 32'h104, 5'b00110);
    // trains PHT[0^6]=6 -> 10, fills BTB[0], BHR becomes 01101
    do_update(32'h100, 1'b1, 32'h200, 5'b00110);
    // predict index 0 ^ 01101 = 13, counter 10 -> taken
    chk("gs_pred_taken", 32'h100, 1'b1, 32'h200, 5'b01101);
    // one NT update into PHT[13] (hist 01101 ^ idx0) -> 01, BHR 11010
    do_update(32'h100, 1'b0, 32'h0, 5'b01101);
    // predict index 0 ^ 11010 = 26, untrained 01 -> not taken
    chk("gs_pred_nt", 32'h100, 1'b0, 32'h104, 5'b11010);
    apply_reset();
    chk("gs_reset_hist", 32'h100, 1'b0, 32'h104, 5'b00000);
`endif

    // drain: bounded wait for the monitor to consume everything
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
